// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if
//   Bundles the observed count bus, its sample controls and the checker's
//   status outputs.
//   master : the side that drives the count (counter or testbench).
//   slave  : the checker, which consumes q_in and reports status.
//   Signals:
//     clr        synchronous clear of checker state and counters
//     en         sample enable
//     q_in       observed count value
//     locked     checker is locked onto a +1 sequence
//     err_pulse  one-cycle pulse on a mismatch while locked
//     err_cnt    saturating mismatch count
//     wrap_pulse one-cycle pulse on a correct max->0 step while locked
//     wrap_cnt   saturating wrap count
//     expected   next expected count value
interface count_seq_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             clr;
  logic             en;
  logic [WIDTH-1:0] q_in;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic             wrap_pulse;
  logic [CNT_W-1:0] wrap_cnt;
  logic [WIDTH-1:0] expected;

  modport master (
    output clr, en, q_in,
    input  locked, err_pulse, err_cnt, wrap_pulse, wrap_cnt, expected
  );

  modport slave (
    input  clr, en, q_in,
    output locked, err_pulse, err_cnt, wrap_pulse, wrap_cnt, expected
  );
endinterface

// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Receive-side monitor for a free-running binary up-counter. Each enabled
//   cycle it samples q_in and checks that it is the previous sample + 1
//   (mod 2^WIDTH). After LOCK_CNT consecutive good steps it declares lock;
//   while locked it reports mismatches and wraps via one-cycle pulses and
//   saturating counters. All outputs are registered.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    count_seq_checker_if slave modport (clr, en, q_in in;
//            locked, err_pulse, err_cnt, wrap_pulse, wrap_cnt, expected out)
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  count_seq_checker_if.slave bus
);

  localparam int RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);
  localparam logic [WIDTH-1:0] Q_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_last;
  logic [RUN_W-1:0] r_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_wrap_pulse;
  logic [CNT_W-1:0] r_wrap_cnt;
  logic [WIDTH-1:0] r_expected;

  logic [WIDTH-1:0] w_last_inc;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_good;

  // Event counters stick at all-ones instead of rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Sum stays WIDTH bits wide so max -> 0 counts as a good step.
  assign w_last_inc = r_last + WIDTH'(1);
  assign w_run_inc  = r_run + RUN_W'(1);
  assign w_good     = (bus.q_in == w_last_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last       <= '0;
      r_run        <= '0;
      r_locked     <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_cnt    <= '0;
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
      r_expected   <= '0;
    end else begin
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      if (bus.clr) begin
        // clr wins over a same-cycle sample, so no check happens here.
        r_state    <= S_IDLE;
        r_last     <= '0;
        r_run      <= '0;
        r_locked   <= 1'b0;
        r_err_cnt  <= '0;
        r_wrap_cnt <= '0;
        r_expected <= '0;
      end else if (bus.en) begin
        r_last     <= bus.q_in;
        r_expected <= bus.q_in + WIDTH'(1);
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_ACQUIRE;
            r_run   <= '0;
          end
          S_ACQUIRE: begin
            if (w_good) begin
              if (w_run_inc == LOCK_V) begin
                r_state  <= S_LOCKED;
                r_run    <= '0;
                r_locked <= 1'b1;
              end else begin
                r_run <= w_run_inc;
              end
            end else begin
              r_run <= '0;
            end
          end
          S_LOCKED: begin
            if (w_good) begin
              if (r_last == Q_MAX) begin
                r_wrap_pulse <= 1'b1;
                r_wrap_cnt   <= sat_inc(r_wrap_cnt);
              end
            end else begin
              // The offending sample is already captured as r_last, so
              // re-acquisition starts from it.
              r_err_pulse <= 1'b1;
              r_err_cnt   <= sat_inc(r_err_cnt);
              r_state     <= S_ACQUIRE;
              r_run       <= '0;
              r_locked    <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_run    <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked     = r_locked;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.wrap_cnt   = r_wrap_cnt;
  assign bus.expected   = r_expected;

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

  typedef struct {
    logic       locked;
    logic       errp;
    logic       wrapp;
    int         errc;
    int         wrapc;
    logic [3:0] expv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  count_seq_checker_if #(.WIDTH(4), .CNT_W(2)) bus_b ();

  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  count_seq_checker #(.WIDTH(4), .LOCK_CNT(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // reference model state (0 idle, 1 acquire, 2 locked)
  int         m_state;
  logic [3:0] m_last;
  int         m_run;
  int         m_errc;
  int         m_wrapc;
  exp_t       m_out;

  task automatic model_reset();
    m_state = 0; m_last = 4'd0; m_run = 0; m_errc = 0; m_wrapc = 0;
    m_out = '{1'b0, 1'b0, 1'b0, 0, 0, 4'd0};
  endtask

  task automatic model_step(input logic c, input logic e, input logic [3:0] q);
    logic good;
    m_out.errp  = 1'b0;
    m_out.wrapp = 1'b0;
    if (c) begin
      model_reset();
    end else if (e) begin
      good = (q == 4'((m_last + 1) % 16));
      if (m_state == 0) begin
        m_state = 1; m_run = 0;
      end else if (m_state == 1) begin
        if (good) begin
          if (m_run + 1 == 2) begin m_state = 2; m_run = 0; end
          else m_run = m_run + 1;
        end else m_run = 0;
      end else begin
        if (good) begin
          if (m_last == 4'd15) begin m_out.wrapp = 1'b1; m_wrapc++; end
        end else begin
          m_out.errp = 1'b1; m_errc++; m_state = 1; m_run = 0;
        end
      end
      m_last = q;
      m_out.expv = 4'((q + 1) % 16);
    end
    m_out.locked = (m_state == 2);
    m_out.errc   = m_errc;
    m_out.wrapc  = m_wrapc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic compare_all(input exp_t x, input string tag);
    chk({tag, ".A.locked"},  32'(bus_a.locked),     32'(x.locked));
    chk({tag, ".A.errp"},    32'(bus_a.err_pulse),  32'(x.errp));
    chk({tag, ".A.wrapp"},   32'(bus_a.wrap_pulse), 32'(x.wrapp));
    chk({tag, ".A.errc"},    32'(bus_a.err_cnt),    32'(sat(x.errc, 255)));
    chk({tag, ".A.wrapc"},   32'(bus_a.wrap_cnt),   32'(sat(x.wrapc, 255)));
    chk({tag, ".A.expected"},32'(bus_a.expected),   32'(x.expv));
    chk({tag, ".B.locked"},  32'(bus_b.locked),     32'(x.locked));
    chk({tag, ".B.errp"},    32'(bus_b.err_pulse),  32'(x.errp));
    chk({tag, ".B.errc"},    32'(bus_b.err_cnt),    32'(sat(x.errc, 3)));
    chk({tag, ".B.wrapc"},   32'(bus_b.wrap_cnt),   32'(sat(x.wrapc, 3)));
  endtask

  task automatic drive(input logic c, input logic e, input logic [3:0] q);
    bus_a.clr = c; bus_a.en = e; bus_a.q_in = q;
    bus_b.clr = c; bus_b.en = e; bus_b.q_in = q;
  endtask

  task automatic step(input logic c, input logic e, input logic [3:0] q, input string tag);
    exp_t x;
    @(negedge clk);
    drive(c, e, q);
    model_step(c, e, q);
    sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb_q.pop_front();
      compare_all(x, tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero;
    logic [3:0] q;
    zero = '{1'b0, 1'b0, 1'b0, 0, 0, 4'd0};
    drive(1'b0, 1'b0, 4'd0);
    model_reset();
    rst_n = 1'b0;
    #12;
    compare_all(zero, "reset");
    @(negedge clk);
    rst_n = 1'b1;

    // acquire and lock on 0,1,2,3
    step(0, 1, 4'd0, "acq0");
    step(0, 1, 4'd1, "acq1");
    step(0, 1, 4'd2, "lock2");
    step(0, 1, 4'd3, "lock3");

    // run through max -> 0 while locked
    for (int i = 4; i < 16; i++) step(0, 1, 4'(i), "run");
    step(0, 1, 4'd0, "wrap0");
    step(0, 1, 4'd1, "wrap1");

    // mismatch while locked, then re-lock
    for (int i = 2; i < 6; i++) step(0, 1, 4'(i), "pre_err");
    step(0, 1, 4'd9,  "err9");
    step(0, 1, 4'd10, "relock10");
    step(0, 1, 4'd11, "relock11");

    // enable gaps hold state
    step(0, 1, 4'd12, "gap_pre");
    for (int i = 13; i < 16; i++) step(0, 1, 4'(i), "gap_pre");
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i), "gap_pre");
    step(0, 0, 4'd7, "gap_hold0");
    step(0, 0, 4'd7, "gap_hold1");
    step(0, 1, 4'd8, "gap_resume");

    // five errors each followed by re-lock; B counters saturate at 3
    q = 4'd8;
    for (int k = 0; k < 5; k++) begin
      q = q + 4'd6;
      step(0, 1, q, "sat_err");
      q = q + 4'd1;
      step(0, 1, q, "sat_acq");
      q = q + 4'd1;
      step(0, 1, q, "sat_lock");
    end

    // asynchronous reset between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(zero, "midrst");
    @(negedge clk);
    rst_n = 1'b1;

    step(0, 1, 4'd0, "post_rst0");
    step(0, 1, 4'd1, "post_rst1");
    step(0, 1, 4'd2, "post_rst2");
    step(0, 1, 4'd14, "pre_clr_err");
    step(0, 1, 4'd15, "pre_clr_acq");
    step(0, 1, 4'd0,  "pre_clr_lock");
    // clr with a bad sample present: no error, everything cleared
    step(1, 1, 4'd9, "clr");
    step(0, 1, 4'd3, "clr_idle");
    step(0, 1, 4'd4, "clr_acq");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
Receive-side monitor for the free-running binary up-counter output bus (q). It samples the count each enabled cycle and checks that it advances by exactly +1 modulo 2^WIDTH. It reports lock status, mismatch errors and wrap events through saturating counters. It sits beside the counter instance as the consumer/checker of its q bus, usable in RTL and on silicon debug paths.

Parameters:
WIDTH, 4, width of the observed count bus
LOCK_CNT, 2, consecutive correct increments required to declare lock (>=1)
CNT_W, 8, width of error and wrap event counters

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of FSM and counters; overrides en
en  input  1  sample enable; q_in is evaluated only when en=1
q_in  input  WIDTH  observed count value
locked  output  1  1 while FSM in LOCKED
err_pulse  output  1  one-cycle pulse on a mismatch detected while LOCKED
err_cnt  output  CNT_W  saturating count of LOCKED mismatches
wrap_pulse  output  1  one-cycle pulse on a correct max->0 step while LOCKED
wrap_cnt  output  CNT_W  saturating count of wraps seen while LOCKED
expected  output  WIDTH  next expected value, (last sample + 1) mod 2^WIDTH

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last=0, run=0, locked=0, err_pulse=0, err_cnt=0, wrap_pulse=0, wrap_cnt=0, expected=0. All outputs are registered.
- Good step: q_in == (last + 1) mod 2^WIDTH, computed in WIDTH bits so 2^WIDTH-1 -> 0 is good.
- Every enabled sample updates last <= q_in and expected <= q_in + 1 (mod 2^WIDTH), in all states.
- en=0 and clr=0: all state and counters hold; err_pulse=wrap_pulse=0.
- clr=1: state=IDLE, run=0, err_cnt=0, wrap_cnt=0, pulses=0, last and expected=0, regardless of en. Takes priority over a same-cycle sample.
- IDLE: the first enabled sample captures last and moves to ACQUIRE with run=0. No check is made.
- ACQUIRE: on a good step, run <= run+1. If run+1 == LOCK_CNT, go to LOCKED with run=0. On a bad step, run <= 0 and the FSM stays in ACQUIRE. Errors are never counted in ACQUIRE.
- LOCKED, good step: stay in LOCKED. If last == 2^WIDTH-1 (step to 0), pulse wrap_pulse for one cycle and increment wrap_cnt.
- LOCKED, bad step: pulse err_pulse for one cycle, increment err_cnt, go to ACQUIRE with run=0. The offending sample becomes last, so re-lock can start from it.
- Latency: flags and counters reflect a sample one clk after the edge at which it was taken. locked rises at the same edge that records the LOCK_CNT-th consecutive good step.
- Saturation: err_cnt and wrap_cnt stick at 2^CNT_W-1; pulses still fire.
- Reset mid-operation: immediate return to the reset values, independent of clk. Operation restarts in IDLE after release.
- run width is ceil(log2(LOCK_CNT+1)) bits.

Test Plan:
- Reset then en=1, q_in=0,1,2,3...: locked=0 after samples 0 and 1, locked=1 after sample 2, err_cnt=0, expected tracks q_in+1.
- Locked, drive 14,15,0,1: wrap_pulse high for exactly one cycle after sample 0, wrap_cnt=1, no err_pulse.
- Locked at 5, inject 9: err_pulse for one cycle, err_cnt=1, locked=0. Then 10,11 gives locked=1 again with err_cnt still 1.
- en toggled 1,0,0,1 with q_in held at 7 during en=0 and 8 at the next enable: no error, state held, locked unchanged.
- CNT_W=2, inject 5 errors, each followed by a re-lock: err_cnt saturates at 3, and err_pulse fires all 5 times.
- Assert rst_n=0 mid-run between clock edges: all outputs drop to 0 immediately. Assert clr=1 with en=1 and a bad q_in: no err_pulse, counters become 0, state goes to IDLE.
